// File: rtl/fc_mul_pkg.sv
// Shared constants, state encoding and width helper for the folded FC multiply stage.
package fc_mul_pkg;

  // Product modes
  localparam int unsigned FC_MUL_XNOR = 0;  // bipolar
  localparam int unsigned FC_MUL_AND  = 1;  // unipolar

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } fc_mul_state_e;

  // Index width that never collapses to zero bits
  function automatic int unsigned fc_mul_idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fc_mul_lane.sv
// One weight row times the held input vector, with an optional popcount of the product.
// Optional feature macro: FC_MUL_POPCNT_EN (adds the popcnt output).
module fc_mul_lane
  import fc_mul_pkg::*;
#(
  parameter int unsigned IDIM = 4,
  parameter int unsigned MODE = FC_MUL_XNOR
) (
  input  logic [IDIM-1:0]            wRow,
  input  logic [IDIM-1:0]            hold,
`ifdef FC_MUL_POPCNT_EN
  output logic [$clog2(IDIM+1)-1:0]  popcnt,
`endif
  output logic [IDIM-1:0]            prod
);

  // Bitwise product of weight row and held input
  always_comb begin
    if (MODE == FC_MUL_AND) begin
      prod = wRow & hold;
    end else begin
      prod = ~(wRow ^ hold);
    end
  end

`ifdef FC_MUL_POPCNT_EN
  localparam int unsigned CntW = $clog2(IDIM + 1);

  // Count of ones in this row's product
  always_comb begin
    popcnt = '0;
    for (int j = 0; j < IDIM; j++) begin
      popcnt = popcnt + CntW'(prod[j]);
    end
  end
`endif

endmodule

// File: rtl/fc_mul_fold_seq.sv
// Folded FC bit-multiply: holds one input vector and emits FOLD product groups of
// ODIM/FOLD rows each through a valid/ready output register.
// Optional feature macro: FC_MUL_POPCNT_EN (registered per-row popcount on oPopcnt).
module fc_mul_fold_seq
  import fc_mul_pkg::*;
#(
  parameter int unsigned IDIM = 4,
  parameter int unsigned ODIM = 4,
  parameter int unsigned FOLD = 2,
  parameter int unsigned MODE = FC_MUL_XNOR,
  localparam int unsigned Rows = ODIM / FOLD,
  localparam int unsigned GrpW = Rows * IDIM,
  localparam int unsigned IdxW = fc_mul_idx_width(FOLD)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                iValid,
  output logic                                iReady,
  input  logic [IDIM-1:0]                     iBit,
  output logic [IdxW-1:0]                     oFoldIdx,
  input  logic [GrpW-1:0]                     wBit,
  output logic                                oValid,
  input  logic                                oReady,
  output logic [GrpW-1:0]                     oFmbs,
  output logic [IdxW-1:0]                     oGrp,
`ifdef FC_MUL_POPCNT_EN
  output logic [Rows*$clog2(IDIM+1)-1:0]      oPopcnt,
`endif
  output logic                                oLast
);

  if (ODIM % FOLD != 0) begin : gParamCheck
    $error("fc_mul_fold_seq: ODIM must be a multiple of FOLD");
  end

  fc_mul_state_e   stateQ, stateD;
  logic [IdxW-1:0] foldQ, foldD;
  logic [IDIM-1:0] holdQ, holdD;
  logic            validD, lastD;
  logic [GrpW-1:0] fmbsD, prod;
  logic [IdxW-1:0] grpD;
  logic            slotFree, lastFold, issue;

`ifdef FC_MUL_POPCNT_EN
  localparam int unsigned CntW = $clog2(IDIM + 1);
  logic [Rows*CntW-1:0] lanePop, popD;
`endif

  for (genvar r = 0; r < Rows; r++) begin : gLane
    fc_mul_lane #(
      .IDIM (IDIM),
      .MODE (MODE)
    ) uLane (
      .wRow   (wBit[r*IDIM +: IDIM]),
      .hold   (holdQ),
`ifdef FC_MUL_POPCNT_EN
      .popcnt (lanePop[r*CntW +: CntW]),
`endif
      .prod   (prod[r*IDIM +: IDIM])
    );
  end

  // Handshake decode; a new vector is only taken as the last group issues
  always_comb begin
    slotFree = !oValid || oReady;
    lastFold = (foldQ == IdxW'(FOLD - 1));
    issue    = (stateQ == StRun) && slotFree;
    iReady   = (stateQ == StIdle) || (issue && lastFold);
    oFoldIdx = foldQ;
  end

  // Next-state: FSM, fold counter, hold register and output group
  always_comb begin
    stateD = stateQ;
    foldD  = foldQ;
    holdD  = holdQ;
    validD = oValid;
    fmbsD  = oFmbs;
    grpD   = oGrp;
    lastD  = oLast;
    case (stateQ)
      StIdle: begin
        // Drain the final group of the previous vector
        if (slotFree) validD = 1'b0;
        if (iValid) begin
          holdD  = iBit;
          foldD  = '0;
          stateD = StRun;
        end
      end
      StRun: begin
        if (issue) begin
          validD = 1'b1;
          fmbsD  = prod;
          grpD   = foldQ;
          lastD  = lastFold;
          if (lastFold) begin
            foldD = '0;
            if (iValid) begin
              holdD = iBit;
            end else begin
              stateD = StIdle;
            end
          end else begin
            foldD = foldQ + IdxW'(1);
          end
        end
      end
      default: stateD = StIdle;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ <= StIdle;
      foldQ  <= '0;
      holdQ  <= '0;
      oValid <= 1'b0;
      oFmbs  <= '0;
      oGrp   <= '0;
      oLast  <= 1'b0;
    end else begin
      stateQ <= stateD;
      foldQ  <= foldD;
      holdQ  <= holdD;
      oValid <= validD;
      oFmbs  <= fmbsD;
      oGrp   <= grpD;
      oLast  <= lastD;
    end
  end

`ifdef FC_MUL_POPCNT_EN
  // Popcount follows oFmbs: loaded on issue, held otherwise
  always_comb begin
    popD = oPopcnt;
    if (issue) popD = lanePop;
  end

  // Popcount register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oPopcnt <= '0;
    end else begin
      oPopcnt <= popD;
    end
  end
`endif

endmodule

// File: tb/tb_fc_mul_fold_seq.sv
// Bench for fc_mul_fold_seq: three instances (XNOR FOLD=2, AND FOLD=2, XNOR FOLD=1)
// share stimulus; a queue scoreboard predicts every output group from the product rule.
module tb_fc_mul_fold_seq;
  import fc_mul_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       iValid;
  logic [3:0] iBit;
  logic       oReady;
  logic [7:0] wmem [2];

  logic       d0IReady, d0FoldIdx, d0OValid, d0OGrp, d0OLast;
  logic [7:0] d0WBit, d0OFmbs;
  logic [5:0] d0Pop;
  logic       d1IReady, d1FoldIdx, d1OValid, d1OGrp, d1OLast;
  logic [7:0] d1WBit, d1OFmbs;
  logic [5:0] d1Pop;
  logic       d2IReady, d2FoldIdx, d2OValid, d2OGrp, d2OLast;
  logic [7:0] d2WBit, d2OFmbs;
  logic [5:0] d2Pop;

  int nTests = 0;
  int nFail  = 0;

  typedef struct packed {
    logic [3:0] vec;
    logic       grp;
    logic       last;
  } expT;

  expT q0[$];
  expT q1[$];
  expT q2[$];

  always #5 clk = ~clk;

  // Combinational weight memory addressed by each instance's fold index
  assign d0WBit = wmem[d0FoldIdx];
  assign d1WBit = wmem[d1FoldIdx];
  assign d2WBit = wmem[d2FoldIdx];

  fc_mul_fold_seq #(.IDIM(4), .ODIM(4), .FOLD(2), .MODE(FC_MUL_XNOR)) dut0 (
    .clk (clk), .rst_n (rst_n), .iValid (iValid), .iReady (d0IReady), .iBit (iBit),
    .oFoldIdx (d0FoldIdx), .wBit (d0WBit), .oValid (d0OValid), .oReady (oReady),
    .oFmbs (d0OFmbs), .oGrp (d0OGrp),
`ifdef FC_MUL_POPCNT_EN
    .oPopcnt (d0Pop),
`endif
    .oLast (d0OLast)
  );

  fc_mul_fold_seq #(.IDIM(4), .ODIM(4), .FOLD(2), .MODE(FC_MUL_AND)) dut1 (
    .clk (clk), .rst_n (rst_n), .iValid (iValid), .iReady (d1IReady), .iBit (iBit),
    .oFoldIdx (d1FoldIdx), .wBit (d1WBit), .oValid (d1OValid), .oReady (oReady),
    .oFmbs (d1OFmbs), .oGrp (d1OGrp),
`ifdef FC_MUL_POPCNT_EN
    .oPopcnt (d1Pop),
`endif
    .oLast (d1OLast)
  );

  fc_mul_fold_seq #(.IDIM(4), .ODIM(2), .FOLD(1), .MODE(FC_MUL_XNOR)) dut2 (
    .clk (clk), .rst_n (rst_n), .iValid (iValid), .iReady (d2IReady), .iBit (iBit),
    .oFoldIdx (d2FoldIdx), .wBit (d2WBit), .oValid (d2OValid), .oReady (oReady),
    .oFmbs (d2OFmbs), .oGrp (d2OGrp),
`ifdef FC_MUL_POPCNT_EN
    .oPopcnt (d2Pop),
`endif
    .oLast (d2OLast)
  );

`ifndef FC_MUL_POPCNT_EN
  assign d0Pop = '0;
  assign d1Pop = '0;
  assign d2Pop = '0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bit b of a group uses weight bit b and input column b mod 4
  function automatic logic [7:0] expProd(input int unsigned mode, input logic [3:0] v,
                                         input logic [7:0] w);
    logic [7:0] r;
    for (int b = 0; b < 8; b++) begin
      if (mode == FC_MUL_AND) r[b] = w[b] && v[b % 4];
      else                    r[b] = (w[b] == v[b % 4]);
    end
    return r;
  endfunction

  function automatic logic [5:0] expPop(input logic [7:0] p);
    logic [5:0] r;
    for (int row = 0; row < 2; row++) begin
      int cnt = 0;
      for (int j = 0; j < 4; j++) cnt += int'(p[row*4 + j]);
      r[row*3 +: 3] = 3'(cnt);
    end
    return r;
  endfunction

  task automatic scoreGroup(input string who, input expT e, input int unsigned mode,
                            input logic [7:0] fmbs, input logic grp, input logic last,
                            input logic [5:0] pop);
    logic [7:0] p;
    p = expProd(mode, e.vec, wmem[e.grp]);
    check({who, " fmbs"}, 32'(fmbs), 32'(p));
    check({who, " grp"}, 32'(grp), 32'(e.grp));
    check({who, " last"}, 32'(last), 32'(e.last));
`ifdef FC_MUL_POPCNT_EN
    check({who, " popcnt"}, 32'(pop), 32'(expPop(p)));
`else
    if (pop !== 6'd0) check({who, " popcnt absent"}, 32'(pop), 32'd0);
`endif
  endtask

  // Scoreboard: retire the presented group before queueing a newly accepted vector
  always @(negedge clk) begin
    if (rst_n) begin
      if (d0OValid && oReady) begin
        check("d0 stray group", 32'(q0.size() != 0), 32'd1);
        if (q0.size() != 0) scoreGroup("d0", q0.pop_front(), FC_MUL_XNOR, d0OFmbs, d0OGrp,
                                       d0OLast, d0Pop);
      end
      if (d1OValid && oReady) begin
        check("d1 stray group", 32'(q1.size() != 0), 32'd1);
        if (q1.size() != 0) scoreGroup("d1", q1.pop_front(), FC_MUL_AND, d1OFmbs, d1OGrp,
                                       d1OLast, d1Pop);
      end
      if (d2OValid && oReady) begin
        check("d2 stray group", 32'(q2.size() != 0), 32'd1);
        if (q2.size() != 0) scoreGroup("d2", q2.pop_front(), FC_MUL_XNOR, d2OFmbs, d2OGrp,
                                       d2OLast, d2Pop);
      end
      if (iValid && d0IReady) begin
        q0.push_back(expT'{vec: iBit, grp: 1'b0, last: 1'b0});
        q0.push_back(expT'{vec: iBit, grp: 1'b1, last: 1'b1});
      end
      if (iValid && d1IReady) begin
        q1.push_back(expT'{vec: iBit, grp: 1'b0, last: 1'b0});
        q1.push_back(expT'{vec: iBit, grp: 1'b1, last: 1'b1});
      end
      if (iValid && d2IReady) q2.push_back(expT'{vec: iBit, grp: 1'b0, last: 1'b1});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    iValid = 1'b0;
    oReady = 1'b1;
    while ((q0.size() + q1.size() + q2.size() != 0 || d0OValid || d1OValid || d2OValid)
           && n < 40) begin
      tick();
      n++;
    end
    check("drain queues", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
    check("drain d0 idle", 32'(d0OValid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n   = 1'b0;
    iValid  = 1'b0;
    iBit    = '0;
    oReady  = 1'b1;
    wmem[0] = 8'hA5;
    wmem[1] = 8'h0F;
    #3;
    check("reset oValid", 32'(d0OValid), 32'd0);
    check("reset oFmbs", 32'(d0OFmbs), 32'd0);
    check("reset oGrp", 32'(d0OGrp), 32'd0);
    check("reset oLast", 32'(d0OLast), 32'd0);
    check("reset oFoldIdx", 32'(d0FoldIdx), 32'd0);
    check("reset iReady", 32'(d0IReady), 32'd1);
    check("reset d2 oValid", 32'(d2OValid), 32'd0);
    check("reset popcnt", 32'(d0Pop), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Directed vector 1010 against A5 / 0F
    iValid = 1'b1;
    iBit   = 4'b1010;
    tick();
    iValid = 1'b0;
    tick();
    check("g0 d0 fmbs", 32'(d0OFmbs), 32'hF0);
    check("g0 d0 grp", 32'(d0OGrp), 32'd0);
    check("g0 d0 last", 32'(d0OLast), 32'd0);
    check("g0 d0 valid", 32'(d0OValid), 32'd1);
    check("g0 d0 foldidx", 32'(d0FoldIdx), 32'd1);
    check("g0 d1 fmbs", 32'(d1OFmbs), 32'hA0);
    check("g0 d2 fmbs", 32'(d2OFmbs), 32'hF0);
    check("g0 d2 last", 32'(d2OLast), 32'd1);
`ifdef FC_MUL_POPCNT_EN
    check("g0 d0 popcnt", 32'(d0Pop), 32'(6'b100_000));
`endif
    tick();
    check("g1 d0 fmbs", 32'(d0OFmbs), 32'h5A);
    check("g1 d0 grp", 32'(d0OGrp), 32'd1);
    check("g1 d0 last", 32'(d0OLast), 32'd1);
    check("g1 d1 fmbs", 32'(d1OFmbs), 32'h0A);
`ifdef FC_MUL_POPCNT_EN
    check("g1 d0 popcnt", 32'(d0Pop), 32'(6'b010_010));
`endif
    tick();
    check("post d0 valid", 32'(d0OValid), 32'd0);
    check("post d0 iReady", 32'(d0IReady), 32'd1);

    // Output stall after the first group
    iValid = 1'b1;
    iBit   = 4'b1010;
    tick();
    iValid = 1'b0;
    tick();
    oReady = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall fmbs", 32'(d0OFmbs), 32'hF0);
      check("stall grp", 32'(d0OGrp), 32'd0);
      check("stall foldidx", 32'(d0FoldIdx), 32'd1);
      check("stall iReady", 32'(d0IReady), 32'd0);
      check("stall valid", 32'(d0OValid), 32'd1);
    end
    oReady = 1'b1;
    tick();
    check("unstall grp", 32'(d0OGrp), 32'd1);
    check("unstall fmbs", 32'(d0OFmbs), 32'h5A);
    tick();
    check("unstall drop", 32'(d0OValid), 32'd0);

    // Back-to-back vectors with iValid held high
    iValid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      check("b2b d0 iReady", 32'(d0IReady), 32'((c % 2) == 0));
      check("b2b d2 iReady", 32'(d2IReady), 32'd1);
      if (c >= 2) begin
        check("b2b d0 valid", 32'(d0OValid), 32'd1);
        check("b2b d0 grp", 32'(d0OGrp), 32'(c % 2));
        check("b2b d2 valid", 32'(d2OValid), 32'd1);
        check("b2b d2 last", 32'(d2OLast), 32'd1);
      end
      iBit = 4'($urandom);
      tick();
    end
    drain();

    // Randomized traffic against the scoreboard
    for (int s = 0; s < 3; s++) begin
      wmem[0] = 8'($urandom);
      wmem[1] = 8'($urandom);
      for (int c = 0; c < 300; c++) begin
        iValid = ($urandom_range(0, 3) != 0);
        iBit   = 4'($urandom);
        oReady = ($urandom_range(0, 3) != 0);
        tick();
      end
      drain();
    end

    // Asynchronous reset while a vector is in flight
    wmem[0] = 8'hA5;
    wmem[1] = 8'h0F;
    iValid  = 1'b1;
    iBit    = 4'b0110;
    tick();
    iValid = 1'b0;
    tick();
    check("rst pre valid", 32'(d0OValid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst d0 valid", 32'(d0OValid), 32'd0);
    check("rst d0 fmbs", 32'(d0OFmbs), 32'd0);
    check("rst d0 foldidx", 32'(d0FoldIdx), 32'd0);
    check("rst d0 iReady", 32'(d0IReady), 32'd1);
    check("rst d2 valid", 32'(d2OValid), 32'd0);
    check("rst d2 fmbs", 32'(d2OFmbs), 32'd0);
    q0.delete();
    q1.delete();
    q2.delete();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rst no stale d0", 32'(d0OValid), 32'd0);
      check("rst no stale d1", 32'(d1OValid), 32'd0);
    end
    check("rst release iReady", 32'(d0IReady), 32'd1);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
